// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_pkg
//  Description : Shared constants for the HD44780 LCD command sequencer:
//                state encoding, LCD word bit positions, init ROM and
//                command codes that need the long execution wait.
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    // State encoding, 3 bits wide
    localparam logic [2:0] ST_PWRUP  = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_ENABLE = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;
    localparam logic [2:0] ST_WAIT   = 3'd5;
    localparam logic [2:0] ST_IDLE   = 3'd6;

    typedef enum logic [2:0] {
        LCD_PWRUP  = ST_PWRUP,
        LCD_LOAD   = ST_LOAD,
        LCD_SETUP  = ST_SETUP,
        LCD_ENABLE = ST_ENABLE,
        LCD_HOLD   = ST_HOLD,
        LCD_WAIT   = ST_WAIT,
        LCD_IDLE   = ST_IDLE
    } lcd_state_e;

    // Bit positions inside the 32-bit LCD output word
    localparam int LCD_BIT_ON    = 31;
    localparam int LCD_BIT_EN    = 10;
    localparam int LCD_BIT_RS    = 9;
    localparam int LCD_BIT_RW    = 8;
    localparam int LCD_DATA_MSB  = 7;
    localparam int LCD_DATA_LSB  = 0;

    // Power-up init: 8-bit/2-line, display on, clear, entry mode increment
    localparam logic [7:0] LCD_INIT_SEQ [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    // Clear and home (0x02 and its 0x03 alias) need the long execution wait
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == LCD_CMD_CLEAR) || (data[7:1] == LCD_CMD_HOME[7:1]));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_delay_counter.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_delay_counter
//  Description : Loadable down-counter that stops at zero. A timed state
//                loads T-1 on entry and exits when the zero flag is set,
//                giving exactly T cycles of residency.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_delay_counter #(
    parameter int               CNT_W   = 20,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    // Load has priority; otherwise count down and saturate at zero
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_one;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_cmd_sequencer
//  Description : Turns byte-wide LCD instructions/data into timed HD44780
//                bus cycles (setup, EN pulse, hold, execution wait). Runs
//                the power-up init sequence autonomously after reset, then
//                accepts one command at a time over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_cmd_sequencer
    import lcd_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 2,
    parameter int T_CMD   = 2000,
    parameter int T_CLR   = 82000,
    parameter int T_PWRUP = 750000,
    parameter int CNT_W   = 20
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_rs,
    input  logic [7:0]  i_cmd_data,
    input  logic        i_lcd_on,
    output logic [31:0] o_io_lcd,
    output logic        o_busy,
    output logic        o_init_done
);

    // Counter reload values: a state lasting T cycles starts at T-1
    localparam logic [CNT_W-1:0] c_ld_setup = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] c_ld_en    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] c_ld_hold  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] c_ld_cmd   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] c_ld_clr   = CNT_W'(T_CLR - 1);
    localparam logic [CNT_W-1:0] c_ld_pwrup = CNT_W'(T_PWRUP - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_val;
    logic             w_cnt_en;
    logic             w_cnt_zero;
    logic [1:0]       r_idx;
    logic             r_cmd_rs;
    logic [7:0]       r_cmd_data;
    logic             r_init_done;
    logic             r_lcd_on;
    logic             w_idle;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_cnt_en = !w_idle;

    lcd_delay_counter #(
        .CNT_W   (CNT_W),
        .RST_VAL (c_ld_pwrup)
    ) u_delay (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_en       (w_cnt_en),
        .o_zero     (w_cnt_zero)
    );

    // Next-state decode and delay-counter reload on entry to each timed state
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_val   = '0;
        case (r_state)
            ST_PWRUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_SETUP;
                w_cnt_load  = 1'b1;
                w_cnt_val   = c_ld_setup;
            end
            ST_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_ENABLE;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = c_ld_en;
                end
            end
            ST_ENABLE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = c_ld_hold;
                end
            end
            ST_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = is_long_cmd(r_cmd_rs, r_cmd_data) ? c_ld_clr : c_ld_cmd;
                end
            end
            ST_WAIT: begin
                if (w_cnt_zero) begin
                    if (!r_init_done && (r_idx != 2'd3)) begin
                        w_state_nxt = ST_LOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    w_state_nxt = ST_SETUP;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = c_ld_setup;
                end
            end
            default: begin
                w_state_nxt = ST_PWRUP;
                w_cnt_load  = 1'b1;
                w_cnt_val   = c_ld_pwrup;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_PWRUP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command register, init index and sticky init-done flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cmd_rs    <= 1'b0;
            r_cmd_data  <= 8'h00;
            r_idx       <= 2'd0;
            r_init_done <= 1'b0;
        end else begin
            if (r_state == ST_LOAD) begin
                r_cmd_rs   <= 1'b0;
                r_cmd_data <= LCD_INIT_SEQ[r_idx];
            end else if (w_idle && i_cmd_valid) begin
                r_cmd_rs   <= i_cmd_rs;
                r_cmd_data <= i_cmd_data;
            end
            if ((r_state == ST_WAIT) && w_cnt_zero && !r_init_done) begin
                if (r_idx != 2'd3) begin
                    r_idx <= r_idx + 2'd1;
                end else begin
                    r_init_done <= 1'b1;
                end
            end
        end
    end

    // Panel power bit follows the request with one cycle of latency
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lcd_on <= 1'b0;
        end else begin
            r_lcd_on <= i_lcd_on;
        end
    end

    // Assemble the LCD word; EN is decoded from state so reset drops it at once
    always_comb begin
        o_io_lcd                             = '0;
        o_io_lcd[LCD_BIT_ON]                 = r_lcd_on;
        o_io_lcd[LCD_BIT_EN]                 = (r_state == ST_ENABLE);
        o_io_lcd[LCD_BIT_RS]                 = r_cmd_rs;
        o_io_lcd[LCD_BIT_RW]                 = 1'b0;
        o_io_lcd[LCD_DATA_MSB:LCD_DATA_LSB]  = r_cmd_data;
    end

    assign o_cmd_ready = w_idle;
    assign o_busy      = !w_idle;
    assign o_init_done = r_init_done;

endmodule
`default_nettype wire

// File: doc/lcd_cmd_sequencer.md
# lcd_cmd_sequencer

Sequencer for the LCD field of the memory-mapped output buffer: it turns byte-wide LCD commands and data into correctly timed HD44780 bus cycles on the 32-bit LCD word. After reset it runs the mandatory power-up and initialisation sequence on its own. It then accepts one command at a time from the LSU side over a valid/ready handshake. It sits between the LSU store path for the LCD address and the `o_io_lcd` pins.

## Interface
Parameters (all counts in `i_clk` cycles, each ≥1):
- `T_SETUP`, 2: RS/DATA setup time before EN rises.
- `T_EN`, 12: EN high width.
- `T_HOLD`, 2: RS/DATA hold time after EN falls.
- `T_CMD`, 2000: execution wait for ordinary commands and data.
- `T_CLR`, 82000: execution wait for clear (0x01) and home (0x02/0x03).
- `T_PWRUP`, 750000: wait after reset before the first init command.
- `CNT_W`, 20: delay counter width; must hold the maximum of all parameters.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `i_clk`, in, 1: clock.
  - `i_rst`, in, 1: asynchronous active-high reset.
- `i_cmd_valid`, in, 1: command request.
- `o_cmd_ready`, out, 1: sequencer can accept a command.
- `i_cmd_rs`, in, 1: 0 = instruction, 1 = data.
- `i_cmd_data`, in, 8: instruction or character byte.
- `i_lcd_on`, in, 1: panel power request.
- `o_io_lcd`, out, 32: bit 31 ON, bit 10 EN, bit 9 RS, bit 8 RW (always 0), bits 7:0 DATA; all other bits 0.
- `o_busy`, out, 1: asserted in every state except IDLE.
- `o_init_done`, out, 1: init sequence complete; sticky until reset.

## Operation
- States: PWRUP, LOAD, SETUP, ENABLE, HOLD, WAIT, IDLE.
- Delay counter:
  - On entry to a timed state it is loaded with T−1.
  - It decrements once per cycle.
  - The state exits in the cycle the counter is 0, so each timed state lasts exactly T cycles.
- PWRUP (T_PWRUP) leads to LOAD.
- LOAD:
  - While init is not done, fetches init ROM entry idx: 0x38, 0x0C, 0x01, 0x06, each with RS=0.
  - Latches the entry into the command register and goes to SETUP.
  - LOAD is one cycle.
- SETUP:
  - Drives RS/DATA from the command register with EN=0, for T_SETUP cycles.
  - Then ENABLE: EN=1 for T_EN cycles.
  - Then HOLD: EN=0, RS/DATA held, for T_HOLD cycles.
  - Then WAIT: RS/DATA held, for T_CLR if RS=0 and DATA∈{0x01,0x02,0x03}, otherwise T_CMD.
- WAIT exit:
  - If init is not done and idx<3: idx++ and go to LOAD.
  - If idx=3: set `o_init_done` and go to IDLE.
  - Otherwise (user command): go to IDLE.
- IDLE:
  - `o_cmd_ready`=1.
  - On `i_cmd_valid`&&`o_cmd_ready`, latch {`i_cmd_rs`, `i_cmd_data`} and go directly to SETUP. There is no LOAD for user commands.
- `o_cmd_ready`=0 in all other states; `i_cmd_valid` outside IDLE is ignored. Requesters hold valid until ready is seen.
- `o_io_lcd[31]`: registered copy of `i_lcd_on`, updated every cycle and independent of the FSM.
- RS/DATA are not cleared on return to IDLE; the last values persist.
- RW is constant 0; reads and busy-flag polling are not supported.

## Timing
- Reset values:
  - `o_io_lcd`=0 (EN, RS, DATA and ON all 0).
  - `o_cmd_ready`=0, `o_busy`=1, `o_init_done`=0.
  - state=PWRUP, idx=0, counter loaded with T_PWRUP−1.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- Handshake at edge k:
  - SETUP occupies cycles k+1..k+T_SETUP, then ENABLE, HOLD and WAIT follow back-to-back.
  - `o_cmd_ready` rises in cycle k+1+T_SETUP+T_EN+T_HOLD+T_wait.
  - The next accept is possible at that edge.
- Init timing:
  - First EN rise occurs at cycle T_PWRUP+1+T_SETUP after reset release.
  - `o_init_done` and `o_cmd_ready` rise together, one cycle after the last WAIT of entry 3.
- Reset mid-operation:
  - All outputs go to reset values immediately.
  - EN drops asynchronously and no partial EN pulse is extended.
  - Init restarts from PWRUP.
- `i_cmd_valid` asserted during init is not accepted; it stays pending until the first IDLE cycle.

## Structure
- Package `lcd_pkg` holds:
  - the state enum `lcd_state_e`;
  - LCD bit-position constants (ON=31, EN=10, RS=9, RW=8, DATA=7:0);
  - the init ROM constants `LCD_INIT_SEQ[4]`;
  - the command codes CLEAR=0x01 and HOME=0x02.
- One sub-module, `lcd_delay_counter`:
  - inputs: load, load value, enable;
  - output: zero flag;
  - width `CNT_W`.
- FSM, command register and init index stay in the top module.

## Test plan
Sim parameters: T_SETUP=1, T_EN=3, T_HOLD=1, T_CMD=5, T_CLR=9, T_PWRUP=10.
- Reset release:
  - `o_io_lcd`=0, ready=0, busy=1 for 10 cycles.
  - First EN pulse carries DATA=0x38 with RS=0.
  - EN is high exactly 3 cycles.
- Init sequence:
  - Four EN pulses: 0x38, 0x0C, 0x01, 0x06.
  - The gap after 0x01 is 9 wait cycles; the others are 5.
  - `o_init_done` and ready rise together afterwards.
- After init, send RS=1, DATA=0x41 (valid for one cycle):
  - RS=1 and DATA=0x41 on the bus one cycle later.
  - EN=1 for 3 cycles.
  - Ready returns 11 cycles after the handshake.
- Back-to-back commands 0x01 then RS=1 0x42, with valid held:
  - Second command is accepted 15 cycles after the first.
  - No overlap of EN pulses.
- Valid asserted at cycle 3 after reset:
  - Not accepted until `o_init_done`=1.
  - Then accepted in the first IDLE cycle.
- Assert `i_rst` while EN=1 during a user command:
  - EN=0 and `o_io_lcd`=0 immediately.
  - Init restarts with 0x38 after 10 cycles.
- Toggle `i_lcd_on`: bit 31 follows with one-cycle latency in every state.
